// File: rtl/inv_key_sched.sv
// inv_key_sched: inverse AES-128 key scheduler.
// Streams the eleven round keys from round 10 down to round 0. Each earlier key is
// recomputed from the later one, so no round-key storage is needed.
//
// Build option: INV_KEY_SCHED_FWD_EN
//   defined   : key_in is the cipher key; ten forward steps run before output starts.
//   undefined : key_in must be the round-10 key; output starts one cycle after load.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   key_valid  in   key_in valid
//   key_ready  out  block can accept a key (idle and not in reset)
//   key_in     in   128-bit key, byte 0 = key_in[0:7]
//   rk_valid   out  rk_out/rk_idx hold a round key
//   rk_ready   in   consumer accepts the round key
//   rk_out     out  round key, words a,b,c,d = [0:31],[32:63],[64:95],[96:127]
//   rk_idx     out  round number of rk_out, 10 down to 0
//   busy       out  not idle
module inv_key_sched (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         key_valid,
   output logic         key_ready,
   input  logic [0:127] key_in,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic [0:127] rk_out,
   output logic [3:0]   rk_idx,
   output logic         busy
);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
`ifdef INV_KEY_SCHED_FWD_EN
      StFwd  = 2'd1,
`endif
      StOut  = 2'd2
   } state_e;

   // FIPS-197 S-box, entry 0 in the top byte.
   localparam logic [2047:0] SboxTbl = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] x);
      // Byte x sits at bits 2047-8x down to 2040-8x.
      return SboxTbl[{~x, 3'b111} -: 8];
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

   function automatic logic [31:0] rcon(input logic [3:0] r);
      logic [7:0] rc;
      case (r)
         4'd1:    rc = 8'h01;
         4'd2:    rc = 8'h02;
         4'd3:    rc = 8'h04;
         4'd4:    rc = 8'h08;
         4'd5:    rc = 8'h10;
         4'd6:    rc = 8'h20;
         4'd7:    rc = 8'h40;
         4'd8:    rc = 8'h80;
         4'd9:    rc = 8'h1b;
         4'd10:   rc = 8'h36;
         default: rc = 8'h00;
      endcase
      return {rc, 24'h000000};
   endfunction

   state_e         state_q, state_d;
   logic [3:0]     r_q, r_d;
   logic [0:127]   key_q, key_d;

   logic [31:0]    wa, wb, wc, wd;
   logic [31:0]    inv_a, inv_b, inv_c, inv_d;

   assign wa = key_q[0:31];
   assign wb = key_q[32:63];
   assign wc = key_q[64:95];
   assign wd = key_q[96:127];

   // Inverse step: undo the XOR chain first, then recover a from the recovered d.
   assign inv_d = wd ^ wc;
   assign inv_c = wc ^ wb;
   assign inv_b = wb ^ wa;
   assign inv_a = wa ^ sub_word(rot_word(inv_d)) ^ rcon(r_q);

`ifdef INV_KEY_SCHED_FWD_EN
   logic [31:0]    fwd_a, fwd_b, fwd_c, fwd_d;

   assign fwd_a = wa ^ sub_word(rot_word(wd)) ^ rcon(r_q + 4'd1);
   assign fwd_b = wb ^ fwd_a;
   assign fwd_c = wc ^ fwd_b;
   assign fwd_d = wd ^ fwd_c;
`endif

   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      key_d   = key_q;
      unique case (state_q)
         StIdle: begin
            if (key_valid) begin
               key_d = key_in;
`ifdef INV_KEY_SCHED_FWD_EN
               r_d     = 4'd0;
               state_d = StFwd;
`else
               r_d     = 4'd10;
               state_d = StOut;
`endif
            end
         end
`ifdef INV_KEY_SCHED_FWD_EN
         StFwd: begin
            key_d = {fwd_a, fwd_b, fwd_c, fwd_d};
            r_d   = r_q + 4'd1;
            if (r_q == 4'd9) begin
               state_d = StOut;
            end
         end
`endif
         StOut: begin
            if (rk_ready) begin
               if (r_q != 4'd0) begin
                  key_d = {inv_a, inv_b, inv_c, inv_d};
                  r_d   = r_q - 4'd1;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         r_q     <= 4'd0;
         key_q   <= '0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         key_q   <= key_d;
      end
   end

   assign key_ready = (state_q == StIdle) && rst_n;
   assign rk_valid  = (state_q == StOut);
   assign rk_out    = key_q;
   assign rk_idx    = r_q;
   assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_inv_key_sched.sv
// Bench for inv_key_sched: table vectors, random keys with random backpressure,
// held key_valid during a stream, and reset mid-stream. Expected round keys come
// from a FIPS-197 forward key expansion with an S-box derived from GF(2^8) math.
module tb_inv_key_sched;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         key_valid;
   logic         key_ready;
   logic [0:127] key_in;
   logic         rk_valid;
   logic         rk_ready;
   logic [0:127] rk_out;
   logic [3:0]   rk_idx;
   logic         busy;

   always #5 clk = ~clk;

   inv_key_sched dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_valid (key_valid),
      .key_ready (key_ready),
      .key_in    (key_in),
      .rk_valid  (rk_valid),
      .rk_ready  (rk_ready),
      .rk_out    (rk_out),
      .rk_idx    (rk_idx),
      .busy      (busy)
   );

`ifdef INV_KEY_SCHED_FWD_EN
   localparam int Lat = 10;
`else
   localparam int Lat = 0;
`endif

   int total = 0;
   int bad   = 0;

   logic [7:0]   sbox_m [256];
   logic [127:0] exp_rk [11];
   logic [127:0] seen   [11];

   typedef struct {
      logic [127:0] key;
      logic [127:0] rk10;
      logic [127:0] rk1;
   } vec_t;
   vec_t tbl [3];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic chkn(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   function automatic logic [7:0] xt(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = xt(a);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      logic [15:0] t = {x, x};
      t = t << n;
      return t[15:8];
   endfunction

   task automatic build_sbox();
      for (int b = 0; b < 256; b++) begin
         logic [7:0] inv = 8'h00;
         for (int x = 1; x < 256; x++) begin
            if (b != 0 && gmul(8'(b), 8'(x)) == 8'h01) inv = 8'(x);
         end
         sbox_m[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4)
                     ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] subw(input logic [31:0] w);
      return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
   endfunction

   // Standard forward expansion; round key k is words 4k..4k+3.
   task automatic set_model(input logic [127:0] k);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
            rc = xt(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   function automatic logic [127:0] kin(input logic [127:0] cipher);
`ifdef INV_KEY_SCHED_FWD_EN
      return cipher;
`else
      return exp_rk[10];
`endif
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [127:0] k);
      int n = 0;
      chkn("load_key_ready", int'(key_ready), 1);
      key_valid = 1'b1;
      key_in    = k;
      step();
      key_valid = 1'b0;
      chkn("load_busy", int'(busy), 1);
      while (!rk_valid && n < 30) begin
         step();
         n++;
      end
      chkn("first_key_latency", n, Lat);
   endtask

   // Consume beats idx 10..0 against exp_rk; stop_at >= 0 returns once that idx shows.
   task automatic drain(input bit rnd, input int stop_at);
      int           e = 10;
      int           cyc = 0;
      bit           hold = 1'b0;
      logic         rdy;
      logic [127:0] prev_out = '0;
      int           prev_idx = 0;
      while (e >= 0 && cyc < 400) begin
         chkn("rk_valid_in_stream", int'(rk_valid), 1);
         if (hold) begin
            chk("hold_rk_out", rk_out, prev_out);
            chkn("hold_rk_idx", int'(rk_idx), prev_idx);
         end
         chkn("rk_idx", int'(rk_idx), e);
         chk("rk_out", rk_out, exp_rk[e]);
         if (e == stop_at) return;
         rdy      = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         rk_ready = rdy;
         prev_out = rk_out;
         prev_idx = int'(rk_idx);
         hold     = !rdy;
         if (rdy) seen[e] = rk_out;
         step();
         cyc++;
         if (rdy) e--;
      end
      chkn("stream_complete", e, -1);
      chkn("end_rk_valid", int'(rk_valid), 0);
      chkn("end_busy", int'(busy), 0);
      chkn("end_key_ready", int'(key_ready), 1);
      rk_ready = 1'b1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [127:0] ka, kb;

      tbl[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                 128'hd014f9a8c9ee2589e13f0cc8b6630ca6,
                 128'ha0fafe1788542cb123a339392a6c7605};
      tbl[1] = '{128'h000102030405060708090a0b0c0d0e0f,
                 128'h13111d7fe3944a17f307a78b4d2b30c5,
                 128'hd6aa74fdd2af72fadaa678f1d6ab76fe};
      tbl[2] = '{128'h00000000000000000000000000000000,
                 128'hb4ef5bcb3e92e21123e951cf6f8f188e,
                 128'h62636363626363636263636362636363};

      build_sbox();

      // Reset state.
      rst_n     = 1'b0;
      key_valid = 1'b0;
      key_in    = '0;
      rk_ready  = 1'b1;
      repeat (3) step();
      chkn("rst_rk_valid", int'(rk_valid), 0);
      chk("rst_rk_out", rk_out, 128'h0);
      chkn("rst_rk_idx", int'(rk_idx), 0);
      chkn("rst_busy", int'(busy), 0);
      chkn("rst_key_ready", int'(key_ready), 0);
      rst_n = 1'b1;
      step();
      chkn("post_rst_key_ready", int'(key_ready), 1);
      repeat (3) step();
      chkn("idle_rk_valid", int'(rk_valid), 0);
      chkn("idle_busy", int'(busy), 0);

      // Known-answer vectors, rk_ready held high.
      for (int v = 0; v < 3; v++) begin
         set_model(tbl[v].key);
`ifdef INV_KEY_SCHED_FWD_EN
         load(tbl[v].key);
`else
         load(tbl[v].rk10);
`endif
         drain(1'b0, -1);
         chk("tbl_rk10", seen[10], tbl[v].rk10);
         chk("tbl_rk1", seen[1], tbl[v].rk1);
         chk("tbl_rk0", seen[0], tbl[v].key);
      end

      // Random keys with random backpressure.
      for (int i = 0; i < 6; i++) begin
         ka = {$urandom(), $urandom(), $urandom(), $urandom()};
         set_model(ka);
         load(kin(ka));
         drain(1'b1, -1);
      end

      // FIPS key under random backpressure gives the same sequence.
      set_model(tbl[0].key);
      load(kin(tbl[0].key));
      drain(1'b1, -1);

      // key_valid held with another key during a stream: ignored until idle.
      ka = tbl[0].key;
      kb = {$urandom(), $urandom(), $urandom(), $urandom()};
      set_model(kb);
      kb = kin(kb);
      set_model(ka);
      load(kin(ka));
      key_valid = 1'b1;
      key_in    = kb;
      drain(1'b0, -1);
      set_model(kb ^ kb ^ ka);
      ka = kb;
      // Rebuild the model for the second key before loading it.
      begin
         logic [127:0] kb_cipher;
         kb_cipher = {$urandom(), $urandom(), $urandom(), $urandom()};
         set_model(kb_cipher);
         load(kin(kb_cipher));
         drain(1'b0, -1);
      end

      // Reset mid-stream at idx 5, then a fresh FIPS load.
      set_model(tbl[0].key);
      load(kin(tbl[0].key));
      drain(1'b0, 5);
      rst_n = 1'b0;
      step();
      chkn("midrst_rk_valid", int'(rk_valid), 0);
      chkn("midrst_rk_idx", int'(rk_idx), 0);
      chkn("midrst_busy", int'(busy), 0);
      rst_n = 1'b1;
      step();
      chkn("midrst_key_ready", int'(key_ready), 1);
      chkn("midrst_no_stale_valid", int'(rk_valid), 0);
      load(kin(tbl[0].key));
      drain(1'b0, -1);
      chk("refill_rk0", seen[0], tbl[0].key);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
